// File: rtl/codificador_posiciones.sv
// codificador_posiciones
// Turns the nine board push-buttons into a 4-bit position code (0-8).
// Buttons are synchronised, debounced, checked for multi-press, and each
// accepted press is offered once on a valid/ack handshake. All buttons must
// be released before the next press is considered.

module codificador_posiciones #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] botones,
  input  logic       enable,
  input  logic       ack,
  output logic [3:0] posicion,
  output logic       valido,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESENT  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Terminal count of the stability counter; the counter never goes past it.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchroniser stages
  logic [8:0] sync_meta_reg;
  logic [8:0] sync_reg;

  // Control state
  state_t     state_reg,    state_next;
  logic [7:0] cnt_reg,      cnt_next;
  logic [8:0] sample_reg,   sample_next;

  // Registered outputs
  logic [3:0] posicion_reg, posicion_next;
  logic       valido_reg,   valido_next;
  logic       error_reg,    error_next;

  // Decoded view of the captured sample
  logic [3:0] enc_terms [0:8];
  logic [3:0] sample_index;
  logic       sample_multi;
  logic       sample_single;

  // Bring the raw asynchronous buttons into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_reg <= '0;
      sync_reg      <= '0;
    end else begin
      sync_meta_reg <= botones;
      sync_reg      <= sync_meta_reg;
    end
  end

  // Each set bit contributes its own index; with a single bit set the OR of
  // all terms is exactly that bit's position.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_enc
      assign enc_terms[gi] = sample_reg[gi] ? 4'(gi) : 4'd0;
    end
  endgenerate

  // OR-reduce the per-bit index terms into the encoded position.
  always_comb begin
    sample_index = 4'd0;
    for (int i = 0; i < 9; i++) begin
      sample_index = sample_index | enc_terms[i];
    end
  end

  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign sample_multi  = |(sample_reg & (sample_reg - 9'd1));
  assign sample_single = (sample_reg != 9'd0) && !sample_multi;

  // State, counter, sample and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 8'd0;
      sample_reg   <= 9'd0;
      posicion_reg <= 4'd0;
      valido_reg   <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      sample_reg   <= sample_next;
      posicion_reg <= posicion_next;
      valido_reg   <= valido_next;
      error_reg    <= error_next;
    end
  end

  // Next-state and next-output logic; valido is high exactly while the next
  // state is PRESENT, error only on the multi-press acceptance cycle.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    sample_next   = sample_reg;
    posicion_next = posicion_reg;
    valido_next   = 1'b0;
    error_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable && (sync_reg != 9'd0)) begin
          sample_next = sync_reg;
          cnt_next    = 8'd0;
          state_next  = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (!enable) begin
          // Press discarded; wait for the buttons to come back up.
          state_next = RELEASE;
        end else if (sync_reg != sample_reg) begin
          // Bounce: quietly start over.
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          if (sample_single) begin
            posicion_next = sample_index;
            valido_next   = 1'b1;
            state_next    = PRESENT;
          end else begin
            // posicion keeps its previous value on a rejected press.
            error_next = 1'b1;
            state_next = RELEASE;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      PRESENT: begin
        // ack and a dropped enable both retire the press the same way.
        if (!enable || ack) begin
          state_next = RELEASE;
        end else begin
          valido_next = 1'b1;
        end
      end

      RELEASE: begin
        if (sync_reg == 9'd0) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign posicion = posicion_reg;
  assign valido   = valido_reg;
  assign error    = error_reg;

endmodule

// File: tb/tb_codificador_posiciones.sv
// Testbench for codificador_posiciones: directed button scenarios, with
// expected events queued by the stimulus and checked by a separate monitor.

module tb_codificador_posiciones;

  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic [8:0] botones;
  logic       enable;
  logic       ack;
  logic [3:0] posicion;
  logic       valido;
  logic       error;

  typedef struct {
    bit       is_err;
    int       pos;
    int       edge_no;
    int       len;      // expected valido length in cycles, 0 = unchecked
  } exp_t;

  exp_t sb[$];

  int cyc    = 0;
  int tests  = 0;
  int failed = 0;

  codificador_posiciones #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .botones  (botones),
    .enable   (enable),
    .ack      (ack),
    .posicion (posicion),
    .valido   (valido),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to time expected events.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue an event for a button change applied at this negedge.
  task automatic expect_ev(input bit is_err, input int pos, input int len);
    exp_t e;
    e.is_err  = is_err;
    e.pos     = pos;
    e.edge_no = cyc + D + 3;
    e.len     = len;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard on each valido rise or error pulse.
  initial begin : monitor
    bit   valido_q = 1'b0;
    bit   error_q  = 1'b0;
    int   vlen     = 0;
    int   elen     = 0;
    int   cur_len  = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (valido && !valido_q) begin
        $display("[TB] valido pos=%0d at edge %0d", posicion, cyc);
        if (sb.size() == 0) begin
          chk("unexpected_valido", 1, 0);
          cur_len = 0;
        end else begin
          e = sb.pop_front();
          chk("kind_valido", 0, int'(e.is_err));
          chk("posicion", int'(posicion), e.pos);
          chk("valido_edge", cyc, e.edge_no);
          cur_len = e.len;
        end
        vlen = 1;
      end else if (valido) begin
        vlen++;
      end
      if (!valido && valido_q && cur_len != 0) chk("valido_len", vlen, cur_len);

      if (error && !error_q) begin
        $display("[TB] error pos=%0d at edge %0d", posicion, cyc);
        if (sb.size() == 0) begin
          chk("unexpected_error", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("kind_error", 1, int'(e.is_err));
          chk("posicion_kept", int'(posicion), e.pos);
          chk("error_edge", cyc, e.edge_no);
        end
        elen = 1;
      end else if (error) begin
        elen++;
      end
      if (!error && error_q) chk("error_len", elen, 1);

      valido_q = valido;
      error_q  = error;
    end
  end

  initial begin : stimulus
    reset   = 1'b1;
    botones = 9'd0;
    enable  = 1'b1;
    ack     = 1'b1;
    tick(3);
    chk("rst_posicion", int'(posicion), 0);
    chk("rst_valido", int'(valido), 0);
    chk("rst_error", int'(error), 0);
    reset = 1'b0;
    tick(4);

    // Clean press with ack tied high, then bit 8.
    expect_ev(0, 4, 1);
    botones = 9'b000010000;
    tick(12);
    botones = 9'd0;
    tick(6);
    expect_ev(0, 8, 1);
    botones = 9'b100000000;
    tick(12);
    botones = 9'd0;
    tick(6);

    // Bounce on bit 2: toggles every 2 cycles, last toggle leaves it high.
    for (int i = 0; i < 5; i++) begin
      botones = (i % 2 == 0) ? 9'b000000100 : 9'd0;
      if (i == 4) expect_ev(0, 2, 1);
      tick(2);
    end
    tick(10);
    botones = 9'd0;
    tick(6);

    // Double press: error pulse, posicion keeps 2, nothing while held.
    expect_ev(1, 2, 0);
    botones = 9'b000000011;
    tick(30);
    chk("double_posicion", int'(posicion), 2);
    botones = 9'd0;
    tick(6);

    // Held-button handshake: valido held 20 cycles until ack.
    ack = 1'b0;
    expect_ev(0, 0, 20);
    botones = 9'b000000001;
    tick(D + 3 + 19);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(20);
    botones = 9'd0;
    tick(6);
    ack = 1'b1;
    expect_ev(0, 0, 1);
    botones = 9'b000000001;
    tick(12);
    botones = 9'd0;
    tick(6);

    // Enable drop during PRESENT.
    ack = 1'b0;
    expect_ev(0, 6, 3);
    botones = 9'b001000000;
    tick(D + 3 + 2);
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(20);
    botones = 9'd0;
    tick(6);
    ack = 1'b1;
    expect_ev(0, 6, 1);
    botones = 9'b001000000;
    tick(12);
    botones = 9'd0;
    tick(6);

    // Asynchronous reset in the middle of DEBOUNCE.
    botones = 9'b000001000;
    tick(4);
    #2 reset = 1'b1;
    #1;
    chk("rstdb_posicion", int'(posicion), 0);
    chk("rstdb_valido", int'(valido), 0);
    chk("rstdb_error", int'(error), 0);
    botones = 9'd0;
    tick(1);
    reset = 1'b0;
    tick(6);

    // Asynchronous reset in the middle of PRESENT.
    ack = 1'b0;
    expect_ev(0, 5, 0);
    botones = 9'b000100000;
    tick(D + 3 + 2);
    #2 reset = 1'b1;
    #1;
    chk("rstpr_posicion", int'(posicion), 0);
    chk("rstpr_valido", int'(valido), 0);
    chk("rstpr_error", int'(error), 0);
    botones = 9'd0;
    tick(1);
    reset = 1'b0;
    tick(6);

    // Fresh press after reset.
    ack = 1'b1;
    expect_ev(0, 7, 1);
    botones = 9'b010000000;
    tick(12);
    botones = 9'd0;
    tick(8);

    chk("pending_events", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/codificador_posiciones.md
# codificador_posiciones

- Converts the nine board push-buttons into a 4-bit board position code (0–8) for the game controller.
- It is the inverse of the position decoder, which turns a 4-bit position back into a one-hot enable.
- The block synchronises and debounces the buttons and rejects multi-button presses.
- It presents each accepted press once through a valid/ack handshake, and requires all buttons released before the next press.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 4 — consecutive stable synchronised cycles required to accept a press; legal range 1–255.

Ports:
- clk  input  1  — single clock; all state changes on its rising edge.
- reset  input  1  — asynchronous, active-high reset.
- botones  input  9  — raw asynchronous buttons, active-high; bit i is board position i.
- enable  input  1  — the game controller accepts moves when high.
- ack  input  1  — controller has consumed the current position.
- posicion  output  4  — encoded position 0–8; registered.
- valido  output  1  — posicion holds an accepted press; registered.
- error  output  1  — one-cycle pulse: more than one button was stable at acceptance; registered.

## Operation

- Synchroniser: two flops on botones, reset to 0. All logic below uses the synchronised value `sync`.
- State machine: IDLE, DEBOUNCE, PRESENT, RELEASE. Reset state is IDLE.
- IDLE:
  - If enable=1 and sync≠0: capture sample=sync, cnt=0, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- DEBOUNCE:
  - If sync≠sample: go to IDLE. No output activity; bounce is absorbed.
  - Else if cnt=DEBOUNCE_CYCLES-1: evaluate sample.
    - Exactly one bit i set: posicion←i, valido←1, go to PRESENT.
    - Two or more bits set: error←1 for one cycle, posicion unchanged, go to RELEASE.
  - Else: cnt←cnt+1.
- PRESENT:
  - valido=1 and posicion is stable.
  - ack=1 at an edge: valido←0, go to RELEASE.
- RELEASE:
  - Stay while sync≠0.
  - When sync=0: go to IDLE.
- enable=0 in DEBOUNCE or PRESENT: valido←0, go to RELEASE. The press is discarded and the button must be released.
- enable=0 in IDLE: no detection.
- ack outside PRESENT: ignored.
- posicion is never cleared except by reset; it retains the last accepted value while valido=0.
- cnt width is 8 bits; it never wraps, because it is bounded by DEBOUNCE_CYCLES-1.

## Timing

- Reset values: posicion=0, valido=0, error=0, state=IDLE, cnt=0, sample=0, synchroniser flops=0.
- Reset asserted mid-operation clears all registers immediately (asynchronously) and drops valido/error in the same cycle.
- Latency: botones stable before rising edge 1 → valido high after rising edge DEBOUNCE_CYCLES+3. With the default, that is edge 7.
- error pulses after that same edge, for exactly one cycle.
- Handshake:
  - valido falls after the first edge at which ack=1 while in PRESENT.
  - If ack is already high when valido rises, valido lasts exactly one cycle.
- Re-arm: after release, sync=0 is seen 2 edges after the buttons drop. RELEASE→IDLE takes one more edge.
- A new press can start debouncing on the following edge.
- Simultaneous enable=0 and ack=1 in PRESENT: both lead to RELEASE with valido←0; the result is identical.

## Test plan

- Clean press: botones=9'b000010000 held, enable=1, ack tied 1 → posicion=4, valido high for exactly one cycle after edge 7. Release botones → next press of bit 8 gives posicion=8.
- Bounce: bit 2 toggles every 2 cycles for 10 cycles, then is held → no valido during bouncing; valido and posicion=2 arrive 7 edges after the last toggle.
- Double press: botones=9'b000000011 held → error high one cycle after edge 7, valido stays 0, posicion keeps its prior value. No further activity until all buttons are released.
- Held-button handshake: press bit 0 with ack=0 → valido stays high for 20 cycles. ack=1 for one cycle → valido drops next edge. The button still held produces no second valido until released and pressed again.
- Enable drop: enable goes to 0 during PRESENT → valido falls next edge. Re-asserting enable with the button still held produces nothing. Release and press again produces valido.
- Async reset: assert reset mid-DEBOUNCE and mid-PRESENT, asynchronously between clock edges → valido=0, error=0, posicion=0 immediately. Normal operation resumes on a fresh press.
